// File: rtl/vx_flush_pkg.sv
// Shared state encoding and line-index type for the dcache flush controller.
package vx_flush_pkg;

    localparam int IDX_FIELD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SWEEP,
        WAIT,
        DONE
    } flush_state_t;

    // Fields are sized for the largest supported geometry; users slice the low bits.
    typedef struct packed {
        logic [IDX_FIELD_W-1:0] bank;
        logic [IDX_FIELD_W-1:0] set;
        logic [IDX_FIELD_W-1:0] way;
    } flush_line_idx_t;

endpackage

// File: rtl/vx_flush_idx_counter.sv
// Nested (bank,set,way) wrap counter, way fastest; last flags the final line of the walk.
module vx_flush_idx_counter
    import vx_flush_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int NUM_SETS  = 64,
    parameter int NUM_WAYS  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output flush_line_idx_t idx,
    output logic            last
);

    localparam logic [IDX_FIELD_W-1:0] BANK_MAX = IDX_FIELD_W'(NUM_BANKS - 1);
    localparam logic [IDX_FIELD_W-1:0] SET_MAX  = IDX_FIELD_W'(NUM_SETS - 1);
    localparam logic [IDX_FIELD_W-1:0] WAY_MAX  = IDX_FIELD_W'(NUM_WAYS - 1);
    localparam logic [IDX_FIELD_W-1:0] ONE      = IDX_FIELD_W'(1);

    logic way_last;
    logic set_last;
    logic bank_last;

    assign way_last  = (idx.way == WAY_MAX);
    assign set_last  = (idx.set == SET_MAX);
    assign bank_last = (idx.bank == BANK_MAX);
    assign last      = way_last && set_last && bank_last;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            idx <= '0;
        end else if (inc) begin
            if (way_last) begin
                idx.way <= '0;
                if (set_last) begin
                    idx.set  <= '0;
                    idx.bank <= bank_last ? '0 : idx.bank + ONE;
                end else begin
                    idx.set <= idx.set + ONE;
                end
            end else begin
                idx.way <= idx.way + ONE;
            end
        end
    end

endmodule

// File: rtl/vx_dcache_flush_ctrl.sv
// Whole-dcache flush sequencer: stall cores, drain, walk every line, await writebacks.
// Optional perf counters are built when DCACHE_FLUSH_PERF_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a flush request
//   DRAIN | cores stalled, waiting for in-flight core traffic to finish
//   SWEEP | issuing one flush request per (bank,set,way)
//   WAIT  | all lines issued, waiting for outstanding responses
//   DONE  | completion presented until accepted
module vx_dcache_flush_ctrl
    import vx_flush_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int NUM_SETS    = 64,
    parameter int NUM_WAYS    = 4,
    parameter int MAX_PENDING = 8,
    parameter int TAG_WIDTH   = 8,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int SET_W      = $clog2(NUM_SETS),
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 core_idle,
    output logic                 core_stall,
    output logic                 flush_req_valid,
    input  logic                 flush_req_ready,
    output logic [BANK_W-1:0]    flush_req_bank,
    output logic [SET_W-1:0]     flush_req_set,
    output logic [WAY_W-1:0]     flush_req_way,
    output logic [TAG_WIDTH-1:0] flush_req_tag,
    input  logic                 flush_rsp_valid,
    input  logic                 flush_rsp_dirty,
    input  logic [TAG_WIDTH-1:0] flush_rsp_tag,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic                 busy
`ifdef DCACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]          perf_dirty_lines,
    output logic [31:0]          perf_flush_cycles
`endif
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    flush_state_t           state;
    flush_state_t           state_next;
    logic [PEND_W-1:0]      pending;
    logic [TAG_WIDTH-1:0]   tag_q;
    flush_line_idx_t        idx;
    logic                   idx_last;
    logic                   start_fire;
    logic                   req_fire;
    logic                   rsp_active;
    logic                   rsp_ok;

    assign start_fire = start_valid && start_ready;
    assign req_fire   = flush_req_valid && flush_req_ready;
    assign rsp_active = (state == SWEEP) || (state == WAIT) || (state == DONE);
    // A response with nothing outstanding is a protocol error; it must not wrap pending.
    assign rsp_ok     = flush_rsp_valid && rsp_active && (pending != '0);

    vx_flush_idx_counter #(
        .NUM_BANKS (NUM_BANKS),
        .NUM_SETS  (NUM_SETS),
        .NUM_WAYS  (NUM_WAYS)
    ) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (start_fire),
        .inc   (req_fire),
        .idx   (idx),
        .last  (idx_last)
    );

    assign flush_req_bank = idx.bank[BANK_W-1:0];
    assign flush_req_set  = idx.set[SET_W-1:0];
    assign flush_req_way  = idx.way[WAY_W-1:0];
    assign flush_req_tag  = tag_q;

    always_comb begin
        state_next      = state;
        start_ready     = 1'b0;
        core_stall      = 1'b1;
        flush_req_valid = 1'b0;
        done_valid      = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                core_stall  = 1'b0;
                busy        = 1'b0;
                if (start_valid) state_next = DRAIN;
            end
            DRAIN: begin
                if (core_idle) state_next = SWEEP;
            end
            SWEEP: begin
                flush_req_valid = (pending < PEND_MAX);
                if (req_fire && idx_last) state_next = WAIT;
            end
            WAIT: begin
                if (pending == '0) state_next = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            tag_q   <= '0;
        end else begin
            state <= state_next;
            if (start_fire) begin
                tag_q <= '0;
            end else if (req_fire) begin
                tag_q <= tag_q + TAG_WIDTH'(1);
            end
            case ({req_fire, rsp_ok})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

`ifdef DCACHE_FLUSH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset || start_fire) begin
            perf_dirty_lines  <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (busy && (perf_flush_cycles != '1)) begin
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
            end
            if (rsp_ok && flush_rsp_dirty && (perf_dirty_lines != '1)) begin
                perf_dirty_lines <= perf_dirty_lines + 32'd1;
            end
        end
    end
`endif

    idx_in_range_a: assert property (@(posedge clk) disable iff (!reset)
        ((idx.bank >> BANK_W) == '0) && ((idx.set >> SET_W) == '0) && ((idx.way >> WAY_W) == '0));

    rsp_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(flush_rsp_valid && rsp_active && (pending == '0)));

    rsp_known_a: assert property (@(posedge clk) disable iff (!reset)
        flush_rsp_valid |-> !$isunknown({flush_rsp_dirty, flush_rsp_tag}));

endmodule

// File: tb/tb_vx_dcache_flush_ctrl.sv
// Self-checking bench for vx_dcache_flush_ctrl: handshake table, directed flush scenarios,
// and randomized ready/response timing checked against a line-order and occupancy model.
module tb_vx_dcache_flush_ctrl;

    localparam int NB    = 4;
    localparam int NS    = 64;
    localparam int NW    = 4;
    localparam int MAXP  = 8;
    localparam int TW    = 8;
    localparam int TOTAL = NB * NS * NW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          core_idle = 1'b0;
    logic          core_stall;
    logic          flush_req_valid;
    logic          flush_req_ready = 1'b0;
    logic [1:0]    flush_req_bank;
    logic [5:0]    flush_req_set;
    logic [1:0]    flush_req_way;
    logic [TW-1:0] flush_req_tag;
    logic          flush_rsp_valid = 1'b0;
    logic          flush_rsp_dirty = 1'b0;
    logic [TW-1:0] flush_rsp_tag = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic          busy;
`ifdef DCACHE_FLUSH_PERF_EN
    logic [31:0]   perf_dirty_lines;
    logic [31:0]   perf_flush_cycles;
`endif

    vx_dcache_flush_ctrl #(
        .NUM_BANKS(NB), .NUM_SETS(NS), .NUM_WAYS(NW), .MAX_PENDING(MAXP), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .core_idle(core_idle), .core_stall(core_stall),
        .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
        .flush_req_bank(flush_req_bank), .flush_req_set(flush_req_set),
        .flush_req_way(flush_req_way), .flush_req_tag(flush_req_tag),
        .flush_rsp_valid(flush_rsp_valid), .flush_rsp_dirty(flush_rsp_dirty),
        .flush_rsp_tag(flush_rsp_tag),
        .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
`ifdef DCACHE_FLUSH_PERF_EN
        , .perf_dirty_lines(perf_dirty_lines), .perf_flush_cycles(perf_flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt, rsp_cnt, dirty_cnt, busy_cnt, model_pend, bubbles;
    int q_tags[$];
    int rsp_mode = 0;    // 0 none, 1 asap, 2 random out-of-order, 3 keep near full, 4 one-shot
    int ready_mode = 0;  // 0 always, 1 random, 2 never
    bit hold_prev;
    logic [17:0] held;
    bit start_seen, done_seen, done_fired;
    int start_cyc, done_cyc;

    typedef struct {
        logic sv, ci, dr;
        logic e_start_ready, e_stall, e_busy, e_req_valid, e_done;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] cur_line();
        return {flush_req_bank, flush_req_set, flush_req_way, flush_req_tag};
    endfunction

    // Expected k-th request of a flush: way fastest, then set, then bank; tag = k mod 256.
    function automatic logic [17:0] exp_line(input int k);
        logic [1:0] b, w;
        logic [5:0] s;
        logic [7:0] t;
        b = 2'(k / (NS * NW));
        s = 6'((k / NW) % NS);
        w = 2'(k % NW);
        t = 8'(k % 256);
        return {b, s, w, t};
    endfunction

    task automatic tick();
        int k;
        int t;
        bit do_rsp;
        @(negedge clk);
        if (reset) begin
            if (hold_prev) check("req_hold", {flush_req_valid, cur_line()}, {1'b1, held});
            if (model_pend >= MAXP) check("over_issue", flush_req_valid, 0);
            if (rsp_mode == 3 && req_cnt > 0 && req_cnt < TOTAL && !flush_req_valid) bubbles++;
            if (busy) busy_cnt++;
            if (start_valid && start_ready) begin
                start_seen = 1; start_cyc = cyc;
                req_cnt = 0; rsp_cnt = 0; dirty_cnt = 0; busy_cnt = 0;
            end
            if (done_valid && !done_seen) begin
                done_seen = 1; done_cyc = cyc;
                check("done_all_issued", req_cnt, TOTAL);
                check("done_all_acked", model_pend, 0);
            end
            if (done_valid && done_ready) done_fired = 1;
            if (flush_req_valid && flush_req_ready) begin
                check("line_order", cur_line(), exp_line(req_cnt));
                req_cnt++;
                q_tags.push_back(int'(flush_req_tag));
                model_pend++;
            end
            if (flush_rsp_valid) begin
                rsp_cnt++;
                dirty_cnt += int'(flush_rsp_dirty);
                model_pend--;
            end
            hold_prev = flush_req_valid && !flush_req_ready;
            held = cur_line();
        end else begin
            hold_prev = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        flush_rsp_valid = 1'b0;
        flush_rsp_dirty = 1'b0;
        do_rsp = 0;
        t = 0;
        if (reset && q_tags.size() > 0) begin
            case (rsp_mode)
                1, 4: begin do_rsp = 1; t = q_tags.pop_front(); end
                2: if ($urandom_range(2) != 0) begin
                    k = $urandom_range(q_tags.size() - 1);
                    t = q_tags[k];
                    q_tags.delete(k);
                    do_rsp = 1;
                end
                3: if (q_tags.size() >= MAXP - 1 || req_cnt == TOTAL) begin
                    do_rsp = 1; t = q_tags.pop_front();
                end
                default: do_rsp = 0;
            endcase
            if (rsp_mode == 4) rsp_mode = 0;
        end
        if (do_rsp) begin
            flush_rsp_valid = 1'b1;
            flush_rsp_tag   = TW'(t);
            flush_rsp_dirty = ((rsp_cnt % 4) == 3);
        end
        case (ready_mode)
            0: flush_req_ready = 1'b1;
            1: flush_req_ready = ($urandom_range(3) != 0);
            default: flush_req_ready = 1'b0;
        endcase
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; start_valid = 1'b0; core_idle = 1'b0; done_ready = 1'b0;
        flush_rsp_valid = 1'b0; rsp_mode = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b1;
        q_tags.delete();
        model_pend = 0; req_cnt = 0; rsp_cnt = 0; dirty_cnt = 0; busy_cnt = 0;
        start_seen = 0; done_seen = 0; done_fired = 0;
    endtask

    task automatic begin_flush(input int drain);
        start_seen = 0; done_seen = 0; done_fired = 0; bubbles = 0;
        core_idle = (drain == 0);
        start_valid = 1'b1;
        for (int i = 0; i < 50 && !start_seen; i++) tick();
        start_valid = 1'b0;
        check("start_accept", start_seen, 1);
        for (int i = 0; i < drain; i++) begin
            check("drain_no_req", flush_req_valid, 0);
            check("drain_stall", core_stall, 1);
            tick();
        end
        core_idle = 1'b1;
        check("drain_exit_cycle", flush_req_valid, 0);
        tick();
        check("sweep_start", flush_req_valid, 1);
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check("done_timeout", done_seen, 1);
    endtask

    task automatic finish_flush(input int delay);
        for (int i = 0; i < delay; i++) begin
            check("done_held", done_valid, 1);
            tick();
        end
        done_ready = 1'b1;
        check("stall_at_done", core_stall, 1);
        tick();
        done_ready = 1'b0;
        check("done_fired", done_fired, 1);
        check("stall_release", core_stall, 0);
        check("idle_start_ready", start_ready, 1);
        check("idle_busy", busy, 0);
        check("total_reqs", req_cnt, TOTAL);
`ifdef DCACHE_FLUSH_PERF_EN
        check("perf_dirty_model", perf_dirty_lines, dirty_cnt);
        check("perf_dirty_256", perf_dirty_lines, TOTAL / 4);
        check("perf_cycles", perf_flush_cycles, busy_cnt);
        tick(); tick();
        check("perf_cycles_hold", perf_flush_cycles, busy_cnt);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           sv    ci    dr    rdy   stall busy  valid done
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        ready_mode = 2;
        do_reset(3);
        for (int i = 0; i < 7; i++) begin
            start_valid = vecs[i].sv; core_idle = vecs[i].ci; done_ready = vecs[i].dr;
            #1;
            check($sformatf("vec%0d_start_ready", i), start_ready, vecs[i].e_start_ready);
            check($sformatf("vec%0d_stall", i), core_stall, vecs[i].e_stall);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_req_valid", i), flush_req_valid, vecs[i].e_req_valid);
            check($sformatf("vec%0d_done", i), done_valid, vecs[i].e_done);
            tick();
        end
        check("table_no_fire", req_cnt, 0);

        // Full in-order flush with minimum latency
        ready_mode = 0;
        do_reset(1);
        rsp_mode = 1;
        begin_flush(0);
        run_to_done(5000);
        check("min_latency", done_cyc - start_cyc - 1, 3 + TOTAL);
        finish_flush(0);

        // Cores slow to drain
        begin_flush(20);
        run_to_done(5000);
        finish_flush(2);

        // No responses: occupancy limit, then one response frees one slot
        rsp_mode = 0;
        begin_flush(0);
        for (int i = 0; i < 30; i++) tick();
        check("cap_reqs", req_cnt, MAXP);
        check("cap_valid_low", flush_req_valid, 0);
        rsp_mode = 4;
        for (int i = 0; i < 5; i++) tick();
        check("one_more_req", req_cnt, MAXP + 1);
        check("cap_valid_low2", flush_req_valid, 0);
        rsp_mode = 1;
        run_to_done(5000);
        finish_flush(0);

        // Near-full with concurrent issue and retire: no issue bubbles
        rsp_mode = 3;
        begin_flush(0);
        run_to_done(5000);
        check("no_bubbles", bubbles, 0);
        finish_flush(1);

        // Reset mid-sweep aborts without completion; next flush restarts at line 0
        rsp_mode = 1;
        begin_flush(0);
        for (int i = 0; i < 2000 && req_cnt < 300; i++) tick();
        check("reached_300", req_cnt, 300);
        do_reset(1);
        check("abort_busy", busy, 0);
        check("abort_stall", core_stall, 0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_done", done_valid, 0);
            tick();
        end

        // Randomized ready/response timing with out-of-order completions
        for (int r = 0; r < 3; r++) begin
            rsp_mode = 2;
            ready_mode = 1;
            begin_flush(int'($urandom_range(5)));
            run_to_done(20000);
            finish_flush(int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
